// File: rtl/pool_stage_pkg.sv
// Shared definitions for the pooling stage: datapath sizes, FSM encoding,
// and the pool_select / pool_window encodings.
package pool_stage_pkg;

  localparam int DWIDTH      = 8;
  localparam int DESIGN_SIZE = 32;
  localparam int MASK_WIDTH  = 32;
  localparam int CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  typedef enum logic {
    SEL_MAX = 1'b0,
    SEL_AVG = 1'b1
  } pool_sel_e;

  localparam logic [1:0] WIN_1    = 2'd0;
  localparam logic [1:0] WIN_2    = 2'd1;
  localparam logic [1:0] WIN_4    = 2'd2;
  localparam logic [1:0] WIN_RSVD = 2'd3;

  // log2(K); the reserved encoding behaves as K=4
  function automatic logic [1:0] win_shift(input logic [1:0] pw);
    case (pw)
      WIN_1:   return 2'd0;
      WIN_2:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/pool_stage_lane.sv
// One lane's pooling accumulator: running signed max or widened sum,
// with the result for the current beat available combinationally.
module pool_lane
  import pool_stage_pkg::*;
#(
  parameter int DWIDTH = pool_stage_pkg::DWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     first,
  input  logic                     avg,
  input  logic [1:0]               shift,
  input  logic signed [DWIDTH-1:0] din,
  output logic signed [DWIDTH-1:0] result
);

  localparam int AW = DWIDTH + 2;

  logic signed [AW-1:0] acc, acc_nxt, din_x, shifted;

  always_comb begin
    din_x = {{2{din[DWIDTH-1]}}, din};
    if (first)
      acc_nxt = din_x;
    else if (avg)
      acc_nxt = acc + din_x;
    else
      acc_nxt = (din_x > acc) ? din_x : acc;
    // two guard bits keep a 4-beat sum exact; the shifted quotient fits DWIDTH
    shifted = avg ? (acc_nxt >>> shift) : acc_nxt;
    result  = shifted[DWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else if (acc_en)
      acc <= acc_nxt;
  end

endmodule

// File: rtl/pool_stage.sv
// Pooling stage between norm and activation: lane-wise max/average over
// windows of 1, 2 or 4 vectors, or a registered masked bypass.
module pool_stage
  import pool_stage_pkg::*;
#(
  parameter int DWIDTH      = pool_stage_pkg::DWIDTH,
  parameter int DESIGN_SIZE = pool_stage_pkg::DESIGN_SIZE,
  parameter int MASK_WIDTH  = pool_stage_pkg::MASK_WIDTH,
  parameter int CNT_WIDTH   = pool_stage_pkg::CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_pool,
  input  logic                          pool_select,
  input  logic [1:0]                    pool_window,
  input  logic [CNT_WIDTH-1:0]          num_vectors,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  pool_state_e state, state_nxt;

  logic                 sel_avg_q;
  logic [1:0]           shift_q;
  logic [CNT_WIDTH-1:0] nvec_q, in_cnt;
  logic [1:0]           win_cnt, k_m1;
  logic                 start, accept, last_beat, win_last, emit;

  logic [DESIGN_SIZE-1:0][DWIDTH-1:0] lane_in, lane_res, pool_data, byp_data;

  assign lane_in   = inp_data;
  assign start     = (state == ST_IDLE) && enable_pool && (num_vectors != '0);
  assign accept    = (state == ST_RUN) && enable_pool && in_data_available;
  assign k_m1      = (shift_q == 2'd0) ? 2'd0 : (shift_q == 2'd1) ? 2'd1 : 2'd3;
  assign last_beat = (in_cnt == nvec_q - CNT_WIDTH'(1));
  assign win_last  = (win_cnt == k_m1);
  assign emit      = accept && (last_beat || win_last);
  assign done_pool = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    if (!enable_pool)
      state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: state_nxt = (num_vectors != '0) ? ST_RUN : ST_DONE;
        ST_RUN:  if (accept && last_beat) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // job configuration is frozen at IDLE->RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_avg_q <= 1'b0;
      shift_q   <= 2'd0;
      nvec_q    <= '0;
    end else if (start) begin
      sel_avg_q <= (pool_select == SEL_AVG);
      shift_q   <= win_shift(pool_window);
      nvec_q    <= num_vectors;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN) begin
      in_cnt  <= '0;
      win_cnt <= 2'd0;
    end else if (accept) begin
      in_cnt  <= in_cnt + CNT_WIDTH'(1);
      win_cnt <= emit ? 2'd0 : win_cnt + 2'd1;
    end
  end

  for (genvar g = 0; g < DESIGN_SIZE; g++) begin : g_lane
    pool_lane #(.DWIDTH(DWIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (!enable_pool),
      .acc_en (accept),
      .first  (win_cnt == 2'd0),
      .avg    (sel_avg_q),
      .shift  (shift_q),
      .din    (lane_in[g]),
      .result (lane_res[g])
    );
  end

  always_comb begin
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      pool_data[i] = validity_mask[i] ? lane_res[i] : '0;
      byp_data[i]  = validity_mask[i] ? lane_in[i]  : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data           <= '0;
      out_data_available <= 1'b0;
    end else if (!enable_pool) begin
      out_data           <= byp_data;
      out_data_available <= in_data_available;
    end else if (emit) begin
      out_data           <= pool_data;
      out_data_available <= 1'b1;
    end else begin
      out_data_available <= 1'b0;
    end
  end

endmodule

// File: doc/pool_stage.md
Name: pool_stage

Overview:
- Pooling stage directly downstream of the normalization block in the TPU output path.
- Consumes one DESIGN_SIZE-lane vector of signed DWIDTH values per beat, which is exactly what norm drives on out_data/out_data_available.
- Reduces every POOL_WINDOW consecutive vectors, lane-wise, to one output vector using max or average, then forwards it to the activation stage.
- When disabled, vectors pass through unchanged with one-cycle latency.

Parameters:
- DWIDTH, 8, bits per lane (signed two's complement).
- DESIGN_SIZE, 32, lanes per vector.
- MASK_WIDTH, 32, validity mask width; must equal DESIGN_SIZE.
- CNT_WIDTH, 8, width of the vector counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable_pool  in  1  1 = pool; 0 = registered bypass.
- pool_select  in  1  0 = max, 1 = average.
- pool_window  in  2  window size K: 0→1, 1→2, 2→4, 3→reserved (treated as 4).
- num_vectors  in  CNT_WIDTH  number of input vectors in the job; 0 means no work.
- in_data_available  in  1  inp_data is valid this cycle.
- inp_data  in  DESIGN_SIZE*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH].
- validity_mask  in  MASK_WIDTH  lane i is valid when bit i = 1.
- out_data  out  DESIGN_SIZE*DWIDTH  pooled vector.
- out_data_available  out  1  one-cycle strobe; out_data is valid.
- done_pool  out  1  job complete; held high while enable_pool remains 1.

Behaviour:
- Reset: clears all state and outputs. out_data=0, out_data_available=0, done_pool=0, FSM=IDLE, in_cnt=0, win_cnt=0, accumulators=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when enable_pool=1 and num_vectors≠0.
  - IDLE→DONE when enable_pool=1 and num_vectors=0. done_pool rises the next cycle.
  - RUN→DONE in the cycle the final window is emitted.
  - DONE→IDLE when enable_pool=0.
  - Any state→IDLE when enable_pool=0. Partial accumulations are discarded and no output is emitted.
- pool_select, pool_window, num_vectors are sampled on IDLE→RUN and held for the whole job.
- Accept rule: a beat is accepted only in RUN with in_data_available=1.
  - in_data_available outside RUN is ignored, except in bypass mode.
  - Each accepted beat increments in_cnt and win_cnt.
- Max: per-lane signed running max. The first beat of a window loads the lane value directly.
- Average: per-lane signed sum of width DWIDTH+2. The first beat loads, later beats add. Result = sum >>> log2(K), arithmetic shift (floor toward −inf), truncated to DWIDTH. For K ≤ 4 the quotient always fits in DWIDTH.
- Emit timing:
  - On the beat where win_cnt reaches K−1, or where in_cnt reaches num_vectors−1, the result is registered.
  - out_data_available pulses the next cycle (latency 1 from the last accepted beat).
  - win_cnt then wraps to 0.
- Back-to-back windows: a beat arriving in the emit cycle starts the next window. No bubble is allowed.
- Partial final window (num_vectors not a multiple of K):
  - Emitted early.
  - Max is taken over the beats received.
  - Average still divides by K (implicit zero padding).
- K=1: every accepted beat is emitted one cycle later; average equals the input.
- Masked lanes (mask bit 0) output 0 in both pool and bypass modes. The mask is sampled with each output's last beat.
- Bypass (enable_pool=0): out_data = masked inp_data and out_data_available = in_data_available, both registered (one-cycle latency). done_pool stays 0.
- Extra beats after in_cnt = num_vectors are ignored.
- Reset asserted mid-job clears everything the next edge. No output pulse follows.

Decomposition:
- Shared package holds:
  - DWIDTH, DESIGN_SIZE, MASK_WIDTH (common with norm and activation);
  - the FSM state encoding (IDLE=0, RUN=1, DONE=2);
  - pool_select and pool_window encodings.
- Sub-module pool_lane: one lane's accumulator (max/sum register, first-beat load, shift-and-truncate output). Instantiated DESIGN_SIZE times in a generate loop.
- Counters, FSM and output strobe stay in the top module.

Test Plan:
- Max pool, K=2, num_vectors=4, mask all 1s. Beats are lane i = 2i−20, 2i−18, 2i−16, 2i−14.
  → Two strobes, each exactly one cycle after beats 2 and 4. Outputs are lane i = 2i−18, then 2i−14. done_pool rises after the second strobe.
- Average, K=4, num_vectors=4. Lane 0 beats = −20, −18, −16, −15 (sum −69).
  → Lane 0 output = −18 (floor). A lane with beats 127, 127, 127, 127 outputs 127 with no overflow.
- Partial window: max, K=4, num_vectors=6, continuous beats.
  → Strobes after beat 4 and beat 6. The second output covers beats 5–6 only. Average mode on the same stimulus divides by 4.
- Bypass with mask 32'hFFFF_0000, inp lane i = 20+i.
  → One-cycle latency. Lanes 0–15 = 0, lanes 16–31 = 36..51. done_pool stays 0.
- enable_pool dropped after 3 of 4 beats (K=4), then re-enabled with a new job.
  → No strobe for the aborted window. The new job's first output uses only new data.
- reset pulsed mid-window.
  → All outputs are 0 the next cycle. A subsequent job produces correct results from a clean state.
